// File: rtl/display_pkg.sv
// Shared types and constants for the display bit-plane datapath.
package display_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StShift,
    StLatch,
    StDisplay
  } state_e;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned R_OFS   = 16;
  localparam int unsigned G_OFS   = 8;
  localparam int unsigned B_OFS   = 0;
  localparam int unsigned PLANES  = 8;

endpackage

// File: rtl/display_line_buffer.sv
// One-row pixel store: single write port, synchronous single read port.
module display_line_buffer
  import display_pkg::*;
#(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 2 * PIXEL_W,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/display_bitplane_serializer.sv
// Buffers one display row and replays it as MSB-first bit planes with
// binary-coded-modulation display times.
module display_bitplane_serializer
  import display_pkg::*;
#(
  parameter int unsigned segments   = 2,
  parameter int unsigned columns    = 64,
  parameter int unsigned base_ticks = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [segments*PIXEL_W-1:0] cpixel,
  input  logic                        cpixel_valid,
  output logic                        cpixel_ready,
  output logic [segments*3-1:0]       rgb,
  output logic                        shift,
  output logic                        latch,
  output logic                        oe,
  output logic [2:0]                  plane,
  output logic                        row_done
);

  localparam int unsigned DataW = segments * PIXEL_W;
  localparam int unsigned ColW  = (columns > 1) ? $clog2(columns) : 1;
  localparam int unsigned CntW  = $clog2(base_ticks * 128) + 1;
  localparam logic [ColW-1:0] LastCol = ColW'(columns - 1);

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [2:0]      plane_q, plane_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q;
  logic            row_done_q, row_done_d;
  logic            we;
  logic [DataW-1:0] rdata;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    row_done_d = 1'b0;
    we         = 1'b0;
    unique case (state_q)
      StLoad: begin
        // ready_q keeps the first post-reset cycle from accepting data.
        if (cpixel_valid && ready_q) begin
          we = 1'b1;
          if (col_q == LastCol) begin
            col_d   = '0;
            plane_d = 3'(PLANES - 1);
            state_d = StShift;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      StShift: begin
        if (col_q == LastCol) begin
          col_d   = '0;
          state_d = StLatch;
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      StLatch: begin
        cnt_d   = CntW'((base_ticks << plane_q) - 1);
        state_d = StDisplay;
      end
      StDisplay: begin
        if (cnt_q == '0) begin
          if (plane_q != 3'd0) begin
            plane_d = plane_q - 3'd1;
            state_d = StShift;
          end else begin
            row_done_d = 1'b1;
            state_d    = StLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      col_q      <= '0;
      plane_q    <= 3'd7;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      ready_q    <= (state_d == StLoad);
      row_done_q <= row_done_d;
    end
  end

  // Reading at the next column index lines the RAM output up with shift.
  display_line_buffer #(
    .Depth (columns),
    .Width (DataW),
    .AddrW (ColW)
  ) u_line_buffer (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (col_q),
    .wdata_i (cpixel),
    .raddr_i (col_d),
    .rdata_o (rdata)
  );

  always_comb begin
    rgb = '0;
    if (state_q == StShift) begin
      for (int s = 0; s < segments; s++) begin
        rgb[3*s]   = rdata[s*PIXEL_W + R_OFS + int'(plane_q)];
        rgb[3*s+1] = rdata[s*PIXEL_W + G_OFS + int'(plane_q)];
        rgb[3*s+2] = rdata[s*PIXEL_W + B_OFS + int'(plane_q)];
      end
    end
  end

  assign cpixel_ready = ready_q;
  assign shift        = (state_q == StShift);
  assign latch        = (state_q == StLatch);
  assign oe           = (state_q == StDisplay);
  assign plane        = plane_q;
  assign row_done     = row_done_q;

endmodule

// File: tb/tb_display_bitplane_serializer.sv
// Randomized bench: a trace model of one row's expected outputs is compared every cycle.
module tb_display_bitplane_serializer;

  localparam int unsigned SEGS = 2;
  localparam int unsigned COLS = 4;
  localparam int unsigned BT   = 2;
  localparam int unsigned PW   = SEGS * 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PW-1:0]     cpixel;
  logic              cpixel_valid;
  logic              cpixel_ready;
  logic [SEGS*3-1:0] rgb;
  logic              shift, latch, oe, row_done;
  logic [2:0]        plane;

  display_bitplane_serializer #(
    .segments   (SEGS),
    .columns    (COLS),
    .base_ticks (BT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpixel       (cpixel),
    .cpixel_valid (cpixel_valid),
    .cpixel_ready (cpixel_ready),
    .rgb          (rgb),
    .shift        (shift),
    .latch        (latch),
    .oe           (oe),
    .plane        (plane),
    .row_done     (row_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              ready;
    logic              shift;
    logic              latch;
    logic              oe;
    logic              row_done;
    logic [2:0]        plane;
    logic [SEGS*3-1:0] rgb;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  logic [PW-1:0] pix [COLS];
  int            beats = 0;
  logic [2:0]    idle_plane = 3'd7;
  int            vectors = 0;
  int            miscompares = 0;
  int            vmode = 0;
  bit            use_fixed = 0;
  logic [PW-1:0] fixed_pix = '0;
  bit            rel_req = 0;

  int sh_cnt[8], white_cnt[8], r0_cnt[8], la_cnt[8], oe_cnt[8];
  int rd_cnt, ovl_cnt, acc_pre, sh_total;
  int oe_exp[8] = '{2, 4, 8, 16, 32, 64, 128, 256};
  int r0_exp[8] = '{0, 0, 0, 0, 0, 0, 0, 4};

  function automatic logic [SEGS*3-1:0] plane_bits(logic [PW-1:0] px, int p);
    logic [SEGS*3-1:0] r;
    for (int s = 0; s < SEGS; s++) begin
      r[3*s]   = px[24*s + 16 + p];
      r[3*s+1] = px[24*s + 8 + p];
      r[3*s+2] = px[24*s + p];
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_pix();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e = '0;
    e.plane = 3'd7;
    return e;
  endfunction

  function automatic exp_t idle_rec();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    e.plane = idle_plane;
    return e;
  endfunction

  // Expected cycle trace for a full row once its last pixel is accepted.
  task automatic build_row();
    exp_t e;
    for (int p = 7; p >= 0; p--) begin
      for (int c = 0; c < COLS; c++) begin
        e = '0; e.shift = 1'b1; e.plane = 3'(p); e.rgb = plane_bits(pix[c], p);
        q.push_back(e);
      end
      e = '0; e.latch = 1'b1; e.plane = 3'(p);
      q.push_back(e);
      for (int t = 0; t < (BT << p); t++) begin
        e = '0; e.oe = 1'b1; e.plane = 3'(p);
        q.push_back(e);
      end
    end
    e = '0; e.ready = 1'b1; e.row_done = 1'b1; e.plane = 3'd0;
    q.push_back(e);
    idle_plane = 3'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int p = 0; p < 8; p++) begin
      sh_cnt[p] = 0; white_cnt[p] = 0; r0_cnt[p] = 0; la_cnt[p] = 0; oe_cnt[p] = 0;
    end
    rd_cnt = 0; ovl_cnt = 0; acc_pre = 0; sh_total = 0;
  endtask

  task automatic tick();
    exp_t got;
    @(negedge clk);
    got = {cpixel_ready, shift, latch, oe, row_done, plane, rgb};
    vectors++;
    if (got !== cur) begin
      miscompares++;
      $display("FAIL cycle @%0t: got rdy,sh,la,oe,rd=%b%b%b%b%b plane=%0d rgb=%b; required %b%b%b%b%b plane=%0d rgb=%b",
               $time, got.ready, got.shift, got.latch, got.oe, got.row_done, got.plane, got.rgb,
               cur.ready, cur.shift, cur.latch, cur.oe, cur.row_done, cur.plane, cur.rgb);
    end
    if (shift) begin
      sh_cnt[plane]++; sh_total++;
      if (rgb == 6'b000111) white_cnt[plane]++;
      if (rgb[0]) r0_cnt[plane]++;
    end
    if (latch) la_cnt[plane]++;
    if (oe) oe_cnt[plane]++;
    if (row_done) rd_cnt++;
    if (oe && shift) ovl_cnt++;

    case (vmode)
      0:       cpixel_valid = 1'($urandom_range(0, 1));
      1:       cpixel_valid = ~cpixel_valid;
      default: cpixel_valid = 1'b1;
    endcase
    if (cur.row_done) cpixel_valid = 1'b0;
    cpixel = (use_fixed && cur.ready) ? fixed_pix : rand_pix();
    if (cpixel_valid && cpixel_ready && sh_total == 0) acc_pre++;
    if (rel_req) begin
      rst_n = 1'b1;
      rel_req = 0;
    end

    if (!rst_n) begin
      cur = reset_rec();
    end else begin
      if (cur.ready && cpixel_valid) begin
        pix[beats] = cpixel;
        beats++;
        if (beats == COLS) begin
          build_row();
          beats = 0;
        end
      end
      cur = (q.size() > 0) ? q.pop_front() : idle_rec();
    end
  endtask

  // kind: 0 random, 1 white on seg 0, 2 R-MSB on seg 0, 3 every-other-cycle load
  task automatic run_row(input int kind);
    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rd_cnt > 0) break;
    end
    chk("row_done pulses", rd_cnt, 1);
    chk("oe/shift overlap", ovl_cnt, 0);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("shift cycles plane %0d", p), sh_cnt[p], COLS);
      chk($sformatf("latch pulses plane %0d", p), la_cnt[p], 1);
      chk($sformatf("oe cycles plane %0d", p), oe_cnt[p], oe_exp[p]);
      if (kind == 1) chk($sformatf("rgb 000111 cycles plane %0d", p), white_cnt[p], 4);
      if (kind == 2) chk($sformatf("rgb[0] cycles plane %0d", p), r0_cnt[p], r0_exp[p]);
    end
    if (kind == 3) chk("beats before first shift", acc_pre, 4);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    cpixel_valid = 1'b0;
    cpixel = '0;
    cur = reset_rec();
    tick();
    tick();
    rel_req = 1;
    tick();

    use_fixed = 1; fixed_pix = {24'h000000, 24'hffffff}; vmode = 0;
    run_row(1);
    fixed_pix = {24'h000000, 24'h800000}; vmode = 2;
    run_row(2);
    use_fixed = 0; vmode = 1;
    run_row(3);
    vmode = 0;
    repeat (3) run_row(0);

    // Asynchronous reset in the middle of plane 4's display window.
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (cur.oe && cur.plane == 3'd4) begin
        found = 1;
        break;
      end
    end
    chk("reached plane 4 display", 32'(found), 1);
    @(posedge clk);
    #1;
    chk("oe before reset", oe, 1);
    chk("plane before reset", plane, 4);
    rst_n = 1'b0;
    #1;
    chk("async reset oe", oe, 0);
    chk("async reset shift/latch/row_done/ready",
        {cpixel_ready, shift, latch, row_done}, 0);
    chk("async reset rgb", rgb, 0);
    chk("async reset plane", plane, 7);
    q.delete();
    beats = 0;
    idle_plane = 3'd7;
    cur = reset_rec();
    tick();
    tick();
    rel_req = 1;
    tick();

    use_fixed = 1; fixed_pix = {24'h000000, 24'hffffff};
    run_row(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_bitplane_serializer.md
# display_bitplane_serializer

Consumes gamma-encoded pixels from `display_color_encoder` (`cpixel`, `segments`×24 bits per column) and turns one display row into bit-plane-serialized panel drive data. Each row is buffered, then every bit plane from MSB to LSB is shifted out one column per cycle, latched, and displayed for a binary-weighted time (BCM). The block sits between the encoder output and the HUB75 pin driver, which turns `shift`, `latch` and `oe` into panel `CLK`, `LAT` and `OE#`.

## Interface
- `segments`, 2: number of panel segments driven in parallel; each segment takes one 24-bit pixel per column.
- `columns`, 64: columns per row, which is also the line buffer depth.
- `base_ticks`, 1: display cycles for bit plane 0. Plane b displays for `base_ticks << b` cycles.

- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous reset, active low.
- `cpixel`  in  segments*24: encoded pixel for the current column. Segment s occupies [24s+23:24s], formatted as 8'R, 8'G, 8'B (MSB first).
- `cpixel_valid`  in  1: `cpixel` is valid this cycle.
- `cpixel_ready`  out  1: the block accepts `cpixel` this cycle.
- `rgb`  out  segments*3: current bit-plane bits. For segment s: [3s] = R bit, [3s+1] = G bit, [3s+2] = B bit.
- `shift`  out  1: `rgb` holds a valid column this cycle; the pin driver pulses panel CLK.
- `latch`  out  1: one-cycle pulse that transfers shifted data to the panel outputs.
- `oe`  out  1: display enable, active high.
- `plane`  out  3: index of the bit plane currently shifting or displaying.
- `row_done`  out  1: one-cycle pulse after the plane-0 display time ends.

## Operation
- States: LOAD → SHIFT → LATCH → DISPLAY → (SHIFT | LOAD).
- **LOAD**
  - `cpixel_ready` = 1.
  - Each cycle with `cpixel_valid`&`cpixel_ready`, write `cpixel` to buffer[col] and increment col.
  - On the beat with col = `columns`-1: set col = 0, set plane = 7, go to SHIFT.
  - Gaps in `cpixel_valid` stall the load; partial state is kept.
- **SHIFT**
  - `shift` = 1; `rgb` = bit `plane` of each channel of buffer[col]; col increments every cycle.
  - After col = `columns`-1: go to LATCH with col = 0.
- **LATCH**: `latch` = 1 for one cycle, then go to DISPLAY with the tick counter loaded to (`base_ticks` << `plane`) − 1.
- **DISPLAY**
  - `oe` = 1; the counter decrements each cycle.
  - At 0 with plane > 0: decrement plane and go to SHIFT.
  - At 0 with plane = 0: pulse `row_done` and go to LOAD.
- `oe` is never high during SHIFT or LATCH; no ghosting overlap is allowed.
- Tick counter width: clog2(`base_ticks` × 128) + 1 bits. No overflow is permitted for any legal parameter.
- Single-buffered: `cpixel_ready` = 0 everywhere outside LOAD.

## Timing
- Reset values: state LOAD, col 0, plane 7, counter 0. All outputs 0 except `plane` = 7. `cpixel_ready` rises in the first cycle after `rst_n` deasserts.
- All outputs are registered or decoded directly from state. `rgb` is a registered read of the buffer, aligned with `shift` in the same cycle, with no bubble between columns.
- Row period: `columns` load beats (minimum) + 8×(`columns` + 1) + `base_ticks`×255 cycles.
- The first `shift` is asserted the cycle after the final load beat is accepted.
- Reset mid-operation: outputs clear immediately (async). The buffer contents are don't-care and are overwritten on the next LOAD.
- `cpixel_valid` outside LOAD is ignored; no data is consumed.

## Structure
- Shared package `display_pkg`:
  - state enum
  - `PIXEL_W` = 24
  - channel bit offsets (R=16, G=8, B=0)
  - `PLANES` = 8
- One sub-module: `display_line_buffer`, a `columns` × (`segments`×24) synchronous-read RAM with one write port and one read port.

## Test plan
- `columns`=4, `segments`=2. Load all pixels {24'h000000, 24'hffffff} → each plane shows 4 `shift` cycles with `rgb` = 6'b000111, then one `latch`.
- Load segment 0 = 24'h800000 (R MSB only) → `rgb`[0] = 1 only while `plane` = 7; 0 for planes 6..0.
- `base_ticks`=2 → `oe` high for 256, 128, …, 2 cycles on planes 7..0. Exactly one `row_done` pulse, then `cpixel_ready` = 1.
- Drive `cpixel_valid` every other cycle during LOAD → exactly 4 beats accepted. SHIFT starts the cycle after the 4th beat. Contents are correct.
- Hold `cpixel_valid` high throughout → `cpixel_ready` is low during SHIFT, LATCH and DISPLAY; no writes occur. `oe` and `shift` are never high together.
- Assert `rst_n` low during DISPLAY of plane 4 → all outputs 0 asynchronously. After release: LOAD, `plane` = 7.
